// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared encodings for the LC3 memory-access stage
// Contents: access-type encodings, FSM state enum, data memory depth.
package lc3_mem_pkg;
    localparam int MEM_DEPTH = 128;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    typedef enum logic [1:0] {
        MS_RD     = 2'd0,
        MS_WR     = 2'd1,
        MS_IND_RD = 2'd2,
        MS_IND_WR = 2'd3
    } mem_state_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_IND,
        S_RD,
        S_WSET,
        S_WR,
        S_DONE
    } fsm_state_e;
endpackage

// File: rtl/lc3_mem_access.sv
// lc3_mem_access: memory-access stage controller (direct/indirect load/store)
// Ports: clock/reset (async, active-high); start/mem_state/m_addr/m_data request
// from execute; dmem_dout/dmem_complete from memory; dmem_addr/dmem_din/dmem_rd
// registered memory pins; memout loaded word; done one-cycle pulse; busy; addr_err.
// Optional feature: define LC3_MEM_ACCESS_ADDR_CHECK_EN to reject addresses
// outside the 128-word memory (addr_err pulses with done, access not issued).
module lc3_mem_access
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mem_state,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    input  logic [DATA_W-1:0] dmem_dout,
    input  logic              dmem_complete,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_din,
    output logic              dmem_rd,
    output logic [DATA_W-1:0] memout,
    output logic              done,
    output logic              busy,
    output logic              addr_err
);
    fsm_state_e        state, state_n;
    mem_state_e        kind, kind_n;
    logic [DATA_W-1:0] data, data_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] din_n, memout_n;
    logic              rd_n, err, err_n;
    logic              m_bad, p_bad;

`ifdef LC3_MEM_ACCESS_ADDR_CHECK_EN
    assign m_bad = |(m_addr >> MEM_AW);
    assign p_bad = |(dmem_dout >> MEM_AW);
`else
    assign m_bad = 1'b0;
    assign p_bad = 1'b0;
`endif

    assign done     = state == S_DONE;
    assign busy     = state != S_IDLE;
    assign addr_err = done && err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            kind      <= MS_RD;
            data      <= '0;
            dmem_addr <= '0;
            dmem_din  <= '0;
            dmem_rd   <= 1'b1;
            memout    <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            kind      <= kind_n;
            data      <= data_n;
            dmem_addr <= addr_n;
            dmem_din  <= din_n;
            dmem_rd   <= rd_n;
            memout    <= memout_n;
            err       <= err_n;
        end
    end

    // Address/data only move on edges where dmem_rd stays high, so the memory
    // never sees a write strobe edge coincide with an address change.
    always_comb begin
        state_n  = state;
        kind_n   = kind;
        data_n   = data;
        addr_n   = dmem_addr;
        din_n    = dmem_din;
        rd_n     = dmem_rd;
        memout_n = memout;
        err_n    = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                kind_n = mem_state_e'(mem_state);
                data_n = m_data;
                if (m_bad) begin
                    state_n = S_DONE;
                    err_n   = 1'b1;
                end else begin
                    addr_n = m_addr;
                    if (mem_state == MS_RD) state_n = S_RD;
                    else if (mem_state == MS_WR) begin
                        state_n = S_WSET;
                        din_n   = m_data;
                    end else state_n = S_IND;
                end
            end
            S_IND: if (dmem_complete) begin
                if (p_bad) begin
                    state_n = S_DONE;
                    err_n   = 1'b1;
                end else begin
                    addr_n = ADDR_W'(dmem_dout);
                    if (kind == MS_IND_RD) state_n = S_RD;
                    else begin
                        state_n = S_WSET;
                        din_n   = data;
                    end
                end
            end
            S_RD: if (dmem_complete) begin
                memout_n = dmem_dout;
                state_n  = S_DONE;
            end
            S_WSET: begin
                rd_n    = 1'b0;
                state_n = S_WR;
            end
            S_WR: if (dmem_complete) begin
                rd_n    = 1'b1;
                state_n = S_DONE;
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lc3_mem_access.sv
// tb_lc3_mem_access: directed self-checking bench for lc3_mem_access
module tb_lc3_mem_access;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mem_state = 2'd0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic [15:0] dmem_dout;
    logic        dmem_complete = 1'b1;
    logic [15:0] dmem_addr, dmem_din, memout;
    logic        dmem_rd, done, busy, addr_err;
    logic [15:0] mem [0:127];
    int          n_chk = 0;
    int          n_fail = 0;

    lc3_mem_access dut (
        .clock(clock), .reset(reset), .start(start), .mem_state(mem_state),
        .m_addr(m_addr), .m_data(m_data), .dmem_dout(dmem_dout),
        .dmem_complete(dmem_complete), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
        .dmem_rd(dmem_rd), .memout(memout), .done(done), .busy(busy), .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    assign dmem_dout = mem[dmem_addr[6:0]];
    always @(posedge clock) if (!dmem_rd && dmem_complete) mem[dmem_addr[6:0]] <= dmem_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request with dmem_complete held high; reports edges to done, write
    // strobe width, last address/data seen during the strobe, stability of
    // address/data across every dmem_rd edge, and addr_err at done.
    task automatic run(input logic [1:0] t, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output int rd_low, output logic stable,
                       output logic [15:0] wa, output logic [15:0] wd, output logic err);
        logic        p_rd;
        logic [15:0] p_a, p_d;
        @(negedge clock);
        start = 1'b1; mem_state = t; m_addr = a; m_data = d; dmem_complete = 1'b1;
        lat = 0; rd_low = 0; stable = 1'b1; wa = 'x; wd = 'x; err = 1'b0;
        p_rd = dmem_rd; p_a = dmem_addr; p_d = dmem_din;
        do begin
            @(negedge clock);
            start = 1'b0;
            lat++;
            if (dmem_rd != p_rd && (dmem_addr != p_a || dmem_din != p_d)) stable = 1'b0;
            if (!dmem_rd) begin rd_low++; wa = dmem_addr; wd = dmem_din; end
            p_rd = dmem_rd; p_a = dmem_addr; p_d = dmem_din;
        end while (!done && lat < 20);
        err = addr_err;
    endtask

    initial begin
        int          lat, rl;
        logic        st, er, frozen;
        logic [15:0] wa, wd;
        @(negedge clock);
        check("rst_rd", dmem_rd, 1);
        check("rst_addr", dmem_addr, 0);
        check("rst_din", dmem_din, 0);
        check("rst_memout", memout, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", addr_err, 0);
        reset = 1'b0;

        run(2'd1, 16'h0010, 16'hBEEF, lat, rl, st, wa, wd, er);
        check("wr_lat", lat, 3);
        check("wr_rdlow", rl, 1);
        check("wr_addr", wa, 16'h0010);
        check("wr_din", wd, 16'hBEEF);
        check("wr_stable", st, 1);
        check("wr_mem", mem[16'h10], 16'hBEEF);
        @(negedge clock);
        check("wr_idle_busy", busy, 0);
        check("wr_idle_done", done, 0);
        check("wr_hold_addr", dmem_addr, 16'h0010);

        run(2'd0, 16'h0010, 16'h0000, lat, rl, st, wa, wd, er);
        check("rd_lat", lat, 2);
        check("rd_memout", memout, 16'hBEEF);
        check("rd_rdlow", rl, 0);

        run(2'd1, 16'h0020, 16'h0030, lat, rl, st, wa, wd, er);
        run(2'd1, 16'h0030, 16'h1234, lat, rl, st, wa, wd, er);
        run(2'd2, 16'h0020, 16'h0000, lat, rl, st, wa, wd, er);
        check("ird_lat", lat, 3);
        check("ird_memout", memout, 16'h1234);

        run(2'd3, 16'h0020, 16'h5555, lat, rl, st, wa, wd, er);
        check("iwr_lat", lat, 4);
        check("iwr_addr", wa, 16'h0030);
        check("iwr_stable", st, 1);
        check("iwr_target", mem[16'h30], 16'h5555);
        check("iwr_pointer", mem[16'h20], 16'h0030);
        check("iwr_memout", memout, 16'h1234);

        // Read stalled for 4 edges, with a store request offered while busy.
        run(2'd1, 16'h0040, 16'hA5A5, lat, rl, st, wa, wd, er);
        @(negedge clock);
        start = 1'b1; mem_state = 2'd0; m_addr = 16'h0040; dmem_complete = 1'b0;
        frozen = 1'b1; lat = 0;
        repeat (5) begin
            @(negedge clock);
            lat++;
            start = 1'b1; mem_state = 2'd1; m_addr = 16'h0050; m_data = 16'h9999;
            if (dmem_addr != 16'h0040 || !dmem_rd || done || !busy || memout != 16'h1234) frozen = 1'b0;
        end
        start = 1'b0; dmem_complete = 1'b1;
        @(negedge clock);
        lat++;
        check("stall_frozen", frozen, 1);
        check("stall_lat", lat, 6);
        check("stall_done", done, 1);
        check("stall_memout", memout, 16'hA5A5);
        @(negedge clock);
        check("drop_busy", busy, 0);
        check("drop_addr", dmem_addr, 16'h0040);
        check("drop_mem", mem[16'h50] === 16'h9999, 0);

        // Reset while the write strobe is low.
        @(negedge clock);
        start = 1'b1; mem_state = 2'd1; m_addr = 16'h0060; m_data = 16'h7777;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("wr_phase_rd", dmem_rd, 0);
        reset = 1'b1;
        #1;
        check("rst_mid_rd", dmem_rd, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_memout", memout, 0);
        @(negedge clock);
        reset = 1'b0;
        run(2'd0, 16'h0010, 16'h0000, lat, rl, st, wa, wd, er);
        check("post_rst_lat", lat, 2);
        check("post_rst_memout", memout, 16'hBEEF);

`ifdef LC3_MEM_ACCESS_ADDR_CHECK_EN
        run(2'd0, 16'h0080, 16'h0000, lat, rl, st, wa, wd, er);
        check("chk_err", er, 1);
        check("chk_done", done, 1);
        check("chk_rdlow", rl, 0);
        check("chk_memout", memout, 16'hBEEF);
        @(negedge clock);
        check("chk_err_clear", addr_err, 0);
`else
        run(2'd1, 16'h0000, 16'h0BAD, lat, rl, st, wa, wd, er);
        run(2'd0, 16'h0080, 16'h0000, lat, rl, st, wa, wd, er);
        check("nochk_err", er, 0);
        check("nochk_lat", lat, 2);
        check("nochk_addr", dmem_addr, 16'h0080);
        check("nochk_memout", memout, 16'h0BAD);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
